// File: rtl/nonrestore_div.sv
// Iterative non-restoring divider: one quotient bit per clock, start/done handshake.
// Define NRDIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module nonrestore_div #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] quotient,
  output logic [DATAWIDTH-1:0] remainder,
  output logic                 div_by_zero
);

  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, ZERO, FIX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  d_q, d_d;
  logic [W:0]    p_q, p_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;

  logic [W-1:0]  a_mag, b_mag;
  logic [W-1:0]  quot_fix, rem_fix, rem_zero;
  logic [W:0]    d_ext, p_sh, p_step;
  logic [W-1:0]  p_fix;

  // P is kept modulo 2^(W+1); only its sign before each step steers add/subtract.
  assign d_ext  = {1'b0, d_q};
  assign p_sh   = {p_q[W-1:0], q_q[W-1]};
  assign p_step = p_q[W] ? (p_sh + d_ext) : (p_sh - d_ext);
  assign p_fix  = p_q[W] ? (p_q[W-1:0] + d_q) : p_q[W-1:0];

`ifdef NRDIV_SIGNED_EN
  logic sign_a_q, sign_a_d;
  logic sign_b_q, sign_b_d;

  assign a_mag    = dividend[W-1] ? -dividend : dividend;
  assign b_mag    = divisor[W-1]  ? -divisor  : divisor;
  assign quot_fix = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
  assign rem_fix  = sign_a_q ? -p_fix : p_fix;
  // Rebuild the original dividend from its magnitude for the divide-by-zero result.
  assign rem_zero = sign_a_q ? -q_q : q_q;
`else
  assign a_mag    = dividend;
  assign b_mag    = divisor;
  assign quot_fix = q_q;
  assign rem_fix  = p_fix;
  assign rem_zero = q_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      q_q      <= '0;
      d_q      <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
`ifdef NRDIV_SIGNED_EN
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      d_q      <= d_d;
      p_q      <= p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
`ifdef NRDIV_SIGNED_EN
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    d_d      = d_q;
    p_d      = p_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
`ifdef NRDIV_SIGNED_EN
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          q_d      = a_mag;
          d_d      = b_mag;
          p_d      = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
`ifdef NRDIV_SIGNED_EN
          sign_a_d = dividend[W-1];
          sign_b_d = divisor[W-1];
`endif
          state_d  = (divisor == '0) ? ZERO : CALC;
        end
      end
      CALC: begin
        p_d   = p_step;
        q_d   = {q_q[W-2:0], ~p_step[W]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          state_d = FIX;
        end
      end
      ZERO: begin
        quot_d  = '1;
        rem_d   = rem_zero;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      FIX: begin
        quot_d  = quot_fix;
        rem_d   = rem_fix;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestore_div.sv
// Directed bench for nonrestore_div: scoreboard of expected results, checked on each done pulse.
`timescale 1ns/1ps
module tb_nonrestore_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  nonrestore_div #(.DATAWIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   qi;
    int   ri;
    e.a = a; e.b = b; e.lat = W + 2; e.dbz = 1'b0;
    qi = 0; ri = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 2;
    end else begin
`ifdef NRDIV_SIGNED_EN
      qi = int'($signed(a)) / int'($signed(b));
      ri = int'($signed(a)) % int'($signed(b));
`else
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
`endif
      e.q = qi[W-1:0];
      e.r = ri[W-1:0];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled by the following rising edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb_q.push_back(model(a, b));
  endtask

  // Waits for done (bounded), optionally pulsing a stray start at cycle pulse_at.
  task automatic wait_done(input int pulse_at);
    exp_t e;
    int   k;
    logic seen;
    logic busy_ok;
    seen = 1'b0;
    busy_ok = 1'b1;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == pulse_at) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      end else if (k == pulse_at + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    e = sb_q.pop_front();
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", k, e.lat);
      chk("busy_during", 32'(busy_ok), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd1);
      chk("quotient", 32'(quotient), 32'(e.q));
      chk("remainder", 32'(remainder), 32'(e.r));
      chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
    end
    $display("op 0x%02h/0x%02h -> q=0x%02h r=0x%02h dbz=%0b cycles=%0d",
             e.a, e.b, quotient, remainder, div_by_zero, k);
  endtask

  // Idle window after an operation: busy must have dropped and no further done may appear.
  task automatic quiet(input int n);
    int dones;
    dones = 0;
    @(negedge clk);
    chk("busy_drop", 32'(busy), 32'd0);
    if (done === 1'b1) dones++;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("extra_done", dones, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_quot"}, 32'(quotient), 32'd0);
    chk({tag, "_rem"}, 32'(remainder), 32'd0);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    int dones;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    start_op(8'd100, 8'd7);   wait_done(0); quiet(3);
    start_op(8'h9C, 8'd7);    wait_done(0); quiet(1);
    start_op(8'd100, 8'hF9);  wait_done(0); quiet(1);
    start_op(8'h80, 8'hFF);   wait_done(0); quiet(1);
    start_op(8'd200, 8'd3);   wait_done(0); quiet(1);
    start_op(8'd37, 8'd0);    wait_done(0); quiet(1);
    start_op(8'd9, 8'd3);     wait_done(0); quiet(1);
    start_op(8'd255, 8'd1);   wait_done(0); quiet(1);
    start_op(8'd0, 8'd5);     wait_done(0); quiet(1);
    start_op(8'd7, 8'd9);     wait_done(0); quiet(1);

    // Stray start mid-operation must be ignored.
    start_op(8'd77, 8'd6);    wait_done(4); quiet(4);

    // Back-to-back: next start raised in the same cycle as done.
    start_op(8'd45, 8'd4);    wait_done(0);
    start_op(8'd13, 8'd0);    wait_done(0);
    start_op(8'd120, 8'd11);  wait_done(0); quiet(2);

    // Reset in the middle of an operation: outputs clear, no done follows.
    dividend = 8'd90; divisor = 8'd9; start = 1'b1;
    dones = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done === 1'b1) dones++;
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet(12);
    chk("midrst_early_done", dones, 0);

    start_op(8'd90, 8'd9);    wait_done(0); quiet(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
